// File: rtl/dss_despread.sv
// DSSS despreader: serial sliding-correlation acquisition of a 31-chip PN phase,
// then one hard data bit per PN period with lock tracking and loss-of-lock detection.
module dss_despread #(
  parameter int         DW       = 8,
  parameter int         THRESH   = 600,
  parameter int         LOSS_MAX = 3,
  parameter logic [4:0] SEED     = 5'b00001
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [DW-1:0] din,
  input  logic                 din_valid,
  output logic                 dout,
  output logic                 dout_valid,
  output logic                 locked,
  output logic signed [DW+4:0] corr
);

  localparam int         AW        = DW + 5;
  localparam logic [4:0] LFSR_LAST = 5'b10000;  // state preceding SEED: 31st chip of a window

  typedef enum logic {
    SEARCH = 1'b0,
    LOCK   = 1'b1
  } state_t;

  state_t                r_state;
  logic [4:0]            r_lfsr;
  logic signed [AW-1:0]  r_acc;
  logic [2:0]            r_miss;
  logic                  r_slip;
  logic                  r_dout;
  logic                  r_dout_valid;
  logic                  r_locked;
  logic signed [AW-1:0]  r_corr;

  state_t                w_state_next;
  logic [4:0]            w_lfsr_next;
  logic signed [AW-1:0]  w_acc_next;
  logic [2:0]            w_miss_next;
  logic                  w_slip_next;
  logic                  w_dout_next;
  logic                  w_dout_valid_next;
  logic                  w_locked_next;
  logic signed [AW-1:0]  w_corr_next;

  logic signed [AW-1:0]  w_din_ext;
  logic signed [AW-1:0]  w_term;
  logic signed [AW-1:0]  w_sum;
  logic [AW-1:0]         w_abs;
  logic                  w_strong;
  logic [2:0]            w_miss_inc;

  assign w_din_ext  = {{(AW-DW){din[DW-1]}}, din};
  assign w_term     = r_lfsr[4] ? w_din_ext : -w_din_ext;
  assign w_sum      = r_acc + w_term;
  assign w_abs      = w_sum[AW-1] ? AW'(-w_sum) : AW'(w_sum);
  assign w_strong   = (w_abs >= AW'(THRESH));
  assign w_miss_inc = r_miss + 3'd1;

  always_comb begin
    w_state_next      = r_state;
    w_lfsr_next       = r_lfsr;
    w_acc_next        = r_acc;
    w_miss_next       = r_miss;
    w_slip_next       = r_slip;
    w_dout_next       = r_dout;
    w_dout_valid_next = 1'b0;
    w_locked_next     = r_locked;
    w_corr_next       = r_corr;

    if (din_valid) begin
      if (r_slip) begin
        // Discarded chip: holding the LFSR shifts local phase by one chip.
        w_slip_next = 1'b0;
      end else begin
        w_lfsr_next = {r_lfsr[3:0], r_lfsr[4] ^ r_lfsr[1]};
        if (r_lfsr == LFSR_LAST) begin
          w_corr_next = w_sum;
          w_acc_next  = '0;
          case (r_state)
            SEARCH: begin
              if (w_strong) begin
                w_state_next  = LOCK;
                w_locked_next = 1'b1;
                w_miss_next   = '0;
              end else begin
                w_slip_next = 1'b1;
              end
            end
            LOCK: begin
              w_dout_next       = ~w_sum[AW-1] && (w_sum != '0);
              w_dout_valid_next = 1'b1;
              if (w_strong) begin
                w_miss_next = '0;
              end else if (w_miss_inc >= 3'(LOSS_MAX)) begin
                w_state_next  = SEARCH;
                w_locked_next = 1'b0;
                w_slip_next   = 1'b1;
                w_miss_next   = '0;
              end else begin
                w_miss_next = w_miss_inc;
              end
            end
            default: begin
              w_state_next = SEARCH;
            end
          endcase
        end else begin
          w_acc_next = w_sum;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= SEARCH;
      r_lfsr       <= SEED;
      r_acc        <= '0;
      r_miss       <= '0;
      r_slip       <= 1'b0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_corr       <= '0;
    end else begin
      r_state      <= w_state_next;
      r_lfsr       <= w_lfsr_next;
      r_acc        <= w_acc_next;
      r_miss       <= w_miss_next;
      r_slip       <= w_slip_next;
      r_dout       <= w_dout_next;
      r_dout_valid <= w_dout_valid_next;
      r_locked     <= w_locked_next;
      r_corr       <= w_corr_next;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign locked     = r_locked;
  assign corr       = r_corr;

endmodule
